apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- APB master that lets two on-chip requesters share one 16-bit APB slave port, such as the team's control-register bank.
- Arbitrates round-robin between requester 0 and requester 1.
- Sequences the SETUP/ACCESS phases, returns read data per requester, and aborts hung transfers with an error after a timeout.
- Sits between firmware-side agents (CPU bridge, debug/JTAG bridge) and the register slave.

Parameters:
- ADDR_W, 16, width of paddr and requester address.
- DATA_W, 16, width of pwdata, prdata and requester data.
- TIMEOUT, 15, maximum ACCESS cycles without pready before abort; legal range 2..255.

Ports:
- pclk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- reqN_valid  in  1  (N=0,1) transfer request; held high with fields stable until reqN_done.
- reqN_write  in  1  (N=0,1) 1=write, 0=read.
- reqN_addr  in  ADDR_W  (N=0,1) target address.
- reqN_wdata  in  DATA_W  (N=0,1) write data.
- reqN_done  out  1  (N=0,1) one-cycle completion pulse.
- reqN_err  out  1  (N=0,1) high with reqN_done when the transfer timed out.
- reqN_rdata  out  DATA_W  (N=0,1) captured read data; holds until the next read completes for that requester.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pwrite  out  1  APB direction.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.

Behaviour:
- All outputs are registered.
- Reset (rstn=0 at an edge) values:
  - State machine: IDLE.
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
  - reqN_done=0, reqN_err=0, reqN_rdata=0, timeout counter=0.
  - last_grant=1, so requester 0 wins the first contention.
- IDLE: psel=0, penable=0.
  - Only one reqN_valid high: grant that requester.
  - Both high: grant the requester that is not last_grant.
  - On grant: latch its addr/wdata/write into paddr/pwdata/pwrite, set last_grant, go to SETUP.
  - Neither high: stay in IDLE.
- SETUP (1 cycle): psel=1, penable=0, go to ACCESS.
- ACCESS: psel=1, penable=1; counter increments each cycle pready=0.
  - pready=1: read transfers capture prdata into the granted reqN_rdata (writes leave it unchanged); go to DONE with err=0.
  - pready=0 with counter==TIMEOUT-1 (TIMEOUT ACCESS cycles elapsed): abort, go to DONE with err=1, reqN_rdata unchanged.
- DONE (1 cycle): psel=0, penable=0, granted reqN_done=1, reqN_err per the outcome.
  - Counter clears; go to IDLE.
  - The requester drops valid at the edge ending DONE; IDLE therefore never re-grants a completed request.
- Latency:
  - Zero-wait slave: valid sampled in IDLE, done 3 cycles later.
  - Back-to-back transfers take 4 cycles each.
- Addresses and data pass through unmodified; no width arithmetic.
- reqN_done/err are never high for both requesters in the same cycle.
- A requester dropping valid mid-transfer does not cancel the transfer; done still pulses.
- Reset mid-transfer: at the next edge psel/penable go to 0, no done pulse is issued, last_grant returns to 1.
- paddr, pwdata and pwrite are stable from SETUP through the end of ACCESS.

Test Plan:
- Write: req0 writes 0x1234 to addr 0x0001 into a zero-wait register slave.
  - psel rises 1 cycle after valid; penable 1 cycle later.
  - req0_done pulses 3 cycles after valid; req0_err=0; the slave register reads 0x1234.
- Read-back: req1 reads addr 0x0001 after the write above.
  - req1_rdata=0x1234 in the req1_done cycle; req0_rdata unchanged.
- Contention: req0 and req1 both valid from reset, each re-requesting immediately after done.
  - Grant order 0,1,0,1; done pulses 4 cycles apart; never simultaneous.
- Wait states: slave holds pready=0 for 3 ACCESS cycles, then 1, prdata=0xBEEF.
  - Done 3 cycles later than the zero-wait case; rdata=0xBEEF; err=0; paddr is stable throughout.
- Timeout: pready tied 0, TIMEOUT=15.
  - Abort after 15 ACCESS cycles; reqN_done=1 and reqN_err=1 in the same cycle; psel low in DONE; the following request proceeds normally.
- Reset mid-ACCESS: rstn=0 for 1 cycle during a wait-stated read.
  - Next cycle psel=0, penable=0, no done pulse, rdata=0.
  - After reset, simultaneous requests grant req0 first.

Source files
------------

// File: rtl/apb_req_arbiter_if.sv
// Bundle of the two requester channels and the APB master bus for apb_req_arbiter.
// The master modport is the arbiter's view; slave is the view of the requesters plus the APB slave.
interface apb_req_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_done;
  logic              req0_err;
  logic [DATA_W-1:0] req0_rdata;

  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_done;
  logic              req1_err;
  logic [DATA_W-1:0] req1_rdata;

  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pwrite;
  logic              psel;
  logic              penable;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_done, req0_err, req0_rdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_done, req1_err, req1_rdata,
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_done, req0_err, req0_rdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_done, req1_err, req1_rdata,
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin APB master: SETUP/ACCESS sequencing, per-requester read data
// capture and timeout abort of transfers whose slave never asserts pready.
module apb_req_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               pclk,
  input  logic               rstn,
  apb_req_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t            r_state;
  logic              r_last_grant;
  logic              r_grant;
  logic [7:0]        r_tmo_cnt;

  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;

  logic              r_done0;
  logic              r_done1;
  logic              r_err0;
  logic              r_err1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_req_any;
  logic              w_pick;
  logic              w_timeout;
  logic              w_pick_write;
  logic [ADDR_W-1:0] w_pick_addr;
  logic [DATA_W-1:0] w_pick_wdata;

  // Contention goes to whichever requester did not win last; a lone request always wins.
  always_comb begin
    w_req_any = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      w_pick = ~r_last_grant;
    end else begin
      w_pick = bus.req1_valid;
    end
    w_pick_write = w_pick ? bus.req1_write : bus.req0_write;
    w_pick_addr  = w_pick ? bus.req1_addr  : bus.req0_addr;
    w_pick_wdata = w_pick ? bus.req1_wdata : bus.req0_wdata;
    w_timeout    = (r_tmo_cnt == TMO_LAST);
  end

  always_ff @(posedge pclk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_tmo_cnt    <= '0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          if (w_req_any) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_pwrite     <= w_pick_write;
            r_paddr      <= w_pick_addr;
            r_pwdata     <= w_pick_wdata;
            r_psel       <= 1'b1;
            r_state      <= S_SETUP;
          end
        end

        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end

        S_ACCESS: begin
          if (bus.pready) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_done0   <= ~r_grant;
            r_done1   <= r_grant;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            if (!r_pwrite) begin
              if (r_grant) begin
                r_rdata1 <= bus.prdata;
              end else begin
                r_rdata0 <= bus.prdata;
              end
            end
            r_state <= S_DONE;
          end else if (w_timeout) begin
            // Abort: completion is reported with error and no read data is captured.
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_done0   <= ~r_grant;
            r_done1   <= r_grant;
            r_err0    <= ~r_grant;
            r_err1    <= r_grant;
            r_state   <= S_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end

        S_DONE: begin
          r_done0   <= 1'b0;
          r_done1   <= 1'b0;
          r_err0    <= 1'b0;
          r_err1    <= 1'b0;
          r_tmo_cnt <= '0;
          r_state   <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.paddr      = r_paddr;
  assign bus.pwdata     = r_pwdata;
  assign bus.pwrite     = r_pwrite;
  assign bus.psel       = r_psel;
  assign bus.penable    = r_penable;
  assign bus.req0_done  = r_done0;
  assign bus.req0_err   = r_err0;
  assign bus.req0_rdata = r_rdata0;
  assign bus.req1_done  = r_done1;
  assign bus.req1_err   = r_err1;
  assign bus.req1_rdata = r_rdata1;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: transaction-timestamp reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_apb_req_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 15;

  logic pclk = 1'b0;
  logic rstn = 1'b0;

  apb_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  apb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .pclk (pclk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- register slave ----------------
  logic [15:0] mem [256];
  int   sl_mode  = 0;   // 0 zero-wait, 1 random, 2 fixed waits, 3 never ready
  int   sl_waits = 0;
  int   sl_cnt   = 0;
  bit   sl_stuck = 0;
  bit   sl_force = 0;
  logic [15:0] sl_data = '0;

  always @(posedge pclk)
    if (bus.psel && bus.penable && bus.pready && bus.pwrite)
      mem[bus.paddr[7:0]] <= bus.pwdata;

  always @(negedge pclk) begin
    logic pr;
    #2;
    if (bus.psel && bus.penable) begin
      case (sl_mode)
        0: pr = 1'b1;
        2: pr = (sl_cnt >= sl_waits);
        3: pr = 1'b0;
        default: begin
          if (sl_cnt == 0) sl_stuck = ($urandom_range(9) == 0);
          pr = !sl_stuck && ($urandom_range(3) != 0);
        end
      endcase
      sl_cnt++;
    end else begin
      sl_cnt = 0;
      pr = 1'($urandom_range(1));
    end
    bus.pready = pr;
    bus.prdata = sl_force ? sl_data : mem[bus.paddr[7:0]];
  end

  // ---------------- reference model ----------------
  // A transfer is described by its grant edge m_g and its finishing edge m_fin;
  // every expected output is derived from those timestamps.
  int  cyc = 0;
  bit  m_en = 0, m_busy = 0, m_owner = 0, m_last = 1, m_err = 0;
  int  m_g = 0, m_fin = -1;
  logic [AW-1:0] m_paddr = '0;
  logic [DW-1:0] m_pwdata = '0, m_rd0 = '0, m_rd1 = '0;
  logic m_pwrite = 1'b0;

  always @(posedge pclk) begin
    bit v0, v1;
    cyc++;
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    if (!rstn) begin
      m_en = 1; m_busy = 0; m_last = 1; m_fin = -1; m_err = 0;
      m_rd0 = '0; m_rd1 = '0; m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0;
    end else if (m_en) begin
      if (!m_busy) begin
        if (v0 || v1) begin
          m_owner  = (v0 && v1) ? !m_last : v1;
          m_last   = m_owner;
          m_busy   = 1;
          m_g      = cyc;
          m_fin    = -1;
          m_paddr  = m_owner ? bus.req1_addr  : bus.req0_addr;
          m_pwdata = m_owner ? bus.req1_wdata : bus.req0_wdata;
          m_pwrite = m_owner ? bus.req1_write : bus.req0_write;
        end
      end else if (m_fin < 0) begin
        if (cyc >= m_g + 2) begin
          if (bus.pready) begin
            m_fin = cyc; m_err = 0;
            if (!m_pwrite) begin
              if (m_owner) m_rd1 = bus.prdata; else m_rd0 = bus.prdata;
            end
          end else if (cyc - (m_g + 2) + 1 == TMO) begin
            m_fin = cyc; m_err = 1;
          end
        end
      end else begin
        m_busy = 0;
      end
    end
  end

  always @(negedge pclk) begin
    bit sel_e, en_e, dn_e;
    if (m_en) begin
      sel_e = m_busy && (m_fin < 0);
      en_e  = sel_e && (cyc >= m_g + 1);
      dn_e  = m_busy && (m_fin >= 0);
      check("bus", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata},
                   {sel_e, en_e, m_pwrite, m_paddr, m_pwdata});
      check("done", {bus.req0_done, bus.req0_err, bus.req1_done, bus.req1_err},
                    {dn_e && !m_owner, dn_e && !m_owner && m_err, dn_e && m_owner, dn_e && m_owner && m_err});
      check("rdata0", bus.req0_rdata, m_rd0);
      check("rdata1", bus.req1_rdata, m_rd1);
      if (bus.req0_done || bus.req1_done) check("excl", bus.req0_done & bus.req1_done, 1'b0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int who, input logic v, input logic wr, input logic [15:0] a, input logic [15:0] d);
    if (who == 0) begin
      bus.req0_valid = v; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  task automatic drop(input int who);
    if (who == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(negedge pclk); #1; end
  endtask

  task automatic xfer(input int who, input logic wr, input logic [15:0] a, input logic [15:0] d,
                      output int t_sel, output int t_en, output int t_done,
                      output logic err, output logic sel_at_done);
    t_sel = -1; t_en = -1; t_done = -1; err = 1'b0; sel_at_done = 1'b1;
    set_req(who, 1'b1, wr, a, d);
    for (int c = 1; c <= 40; c++) begin
      step(1);
      if (bus.psel && t_sel < 0) t_sel = c;
      if (bus.penable && t_en < 0) t_en = c;
      if ((who == 0) ? bus.req0_done : bus.req1_done) begin
        t_done = c;
        err = (who == 0) ? bus.req0_err : bus.req1_err;
        sel_at_done = bus.psel;
        break;
      end
    end
    drop(who);
  endtask

  int ts, te, td;
  logic er, sd;
  int ord [4];
  int tm  [4];
  int n;
  int first;

  initial begin
    foreach (mem[i]) mem[i] = '0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    rstn = 1'b0;
    step(3);
    check("rst_psel",   bus.psel, 1'b0);
    check("rst_pen",    bus.penable, 1'b0);
    check("rst_paddr",  bus.paddr, 16'h0000);
    check("rst_rdata",  {bus.req0_rdata, bus.req1_rdata}, 32'h0);
    rstn = 1'b1;
    step(2);

    // zero-wait write from req0
    sl_mode = 0;
    xfer(0, 1'b1, 16'h0001, 16'h1234, ts, te, td, er, sd);
    check("wr_tsel",  ts, 1);
    check("wr_ten",   te, 2);
    check("wr_tdone", td, 3);
    check("wr_err",   er, 1'b0);
    check("wr_mem",   mem[1], 16'h1234);
    step(2);

    // read-back by req1
    xfer(1, 1'b0, 16'h0001, 16'h0000, ts, te, td, er, sd);
    check("rb_tdone", td, 3);
    check("rb_rdata1", bus.req1_rdata, 16'h1234);
    check("rb_rdata0", bus.req0_rdata, 16'h0000);
    step(2);

    // three wait states
    sl_mode = 2; sl_waits = 3; sl_force = 1; sl_data = 16'hBEEF;
    xfer(0, 1'b0, 16'h0020, 16'h0000, ts, te, td, er, sd);
    check("ws_tdone", td, 6);
    check("ws_rdata", bus.req0_rdata, 16'hBEEF);
    check("ws_err",   er, 1'b0);
    sl_force = 0;
    step(2);

    // timeout, then a normal transfer
    sl_mode = 3;
    xfer(1, 1'b1, 16'h0005, 16'h5555, ts, te, td, er, sd);
    check("to_tdone", td, 17);
    check("to_err",   er, 1'b1);
    check("to_psel",  sd, 1'b0);
    check("to_mem",   mem[5], 16'h0000);
    step(2);
    sl_mode = 0;
    xfer(1, 1'b0, 16'h0001, 16'h0000, ts, te, td, er, sd);
    check("post_tdone", td, 3);
    check("post_err",   er, 1'b0);
    check("post_rdata", bus.req1_rdata, 16'h1234);
    step(2);

    // contention from reset, both re-requesting immediately
    rstn = 1'b0;
    set_req(0, 1'b1, 1'b1, 16'h0002, 16'hAAAA);
    set_req(1, 1'b1, 1'b1, 16'h0003, 16'hBBBB);
    step(2);
    rstn = 1'b1;
    n = 0;
    for (int c = 1; c <= 60 && n < 4; c++) begin
      step(1);
      if (bus.req0_done && n < 4) begin ord[n] = 0; tm[n] = c; n++; end
      if (bus.req1_done && n < 4) begin ord[n] = 1; tm[n] = c; n++; end
    end
    drop(0); drop(1);
    check("ct_count", n, 4);
    check("ct_order", {ord[0][1:0], ord[1][1:0], ord[2][1:0], ord[3][1:0]}, 8'b00_01_00_01);
    check("ct_gap",   {tm[1] - tm[0], tm[2] - tm[1], tm[3] - tm[2]}, {32'd4, 32'd4, 32'd4});
    step(3);

    // reset during a wait-stated read
    xfer(0, 1'b0, 16'h0001, 16'h0000, ts, te, td, er, sd);
    check("mr_pre_rdata", bus.req0_rdata, 16'h1234);
    step(2);
    sl_mode = 2; sl_waits = 6;
    set_req(0, 1'b1, 1'b0, 16'h0001, 16'h0000);
    for (int c = 0; c < 10 && !bus.penable; c++) step(1);
    check("mr_in_access", bus.penable, 1'b1);
    step(1);
    rstn = 1'b0;
    drop(0);
    step(1);
    check("mr_psel",  bus.psel, 1'b0);
    check("mr_pen",   bus.penable, 1'b0);
    check("mr_done",  bus.req0_done, 1'b0);
    check("mr_rdata", bus.req0_rdata, 16'h0000);
    rstn = 1'b1;
    sl_mode = 0;
    set_req(0, 1'b1, 1'b0, 16'h0001, 16'h0000);
    set_req(1, 1'b1, 1'b0, 16'h0002, 16'h0000);
    first = -1;
    for (int c = 0; c < 20 && first < 0; c++) begin
      step(1);
      if (bus.req0_done) first = 0;
      else if (bus.req1_done) first = 1;
    end
    check("mr_first", first, 0);
    drop(0); drop(1);
    step(6);

    // randomized traffic
    sl_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      if (bus.req0_valid && bus.req0_done) drop(0);
      else if (!bus.req0_valid && $urandom_range(2) == 0)
        set_req(0, 1'b1, 1'($urandom_range(1)), 16'($urandom), 16'($urandom));
      if (bus.req1_valid && bus.req1_done) drop(1);
      else if (!bus.req1_valid && $urandom_range(2) == 0)
        set_req(1, 1'b1, 1'($urandom_range(1)), 16'($urandom), 16'($urandom));
      step(1);
    end
    drop(0); drop(1);
    step(25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
